// File: rtl/swim_rx_pkg.sv
// Shared SWIM definitions: frame length, low-speed timing at 48 MHz and
// receiver FSM encodings. Also used by the transmitter side.
package swim_rx_pkg;

  localparam int SWIM_FRAME_BITS = 10;
  localparam int SWIM_SHORT_LOW  = 12;
  localparam int SWIM_LONG_LOW   = 120;
  localparam int SWIM_BIT_PERIOD = 132;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOW     = 3'd1,
    ST_HIGH    = 3'd2,
    ST_STUCK   = 3'd3,
    ST_DISCARD = 3'd4
  } rx_state_t;

endpackage

// File: rtl/swim_sync.sv
// Two-flop synchronizer for the swim pad with rise/fall pulses on the
// synced value. Idles high (line released) out of reset.
module swim_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic prev;

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from pre-edge values; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta  <= 1'b1;
      level <= 1'b1;
      prev  <= 1'b1;
    end else begin
      meta  <= din;
      level <= meta;
      prev  <= level;
    end
  end

  assign rise = level & ~prev;
  assign fall = ~level & prev;

endmodule

// File: rtl/swim_rx.sv
// SWIM receiver: times low pulses, decodes header + 8 data + parity frames
// and presents good bytes on a valid/ready stream.
module swim_rx
  import swim_rx_pkg::*;
#(
  parameter int BIT_THRESH = 66,
  parameter int GLITCH_MIN = 4,
  parameter int TIMEOUT    = 2048,
  parameter int CNT_W      = 12
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       swim_in,
  input  logic       en,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun
);

  rx_state_t        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic [3:0]       bit_cnt, bit_cnt_n;
  logic [9:0]       shreg, shreg_n, frame;
  logic             level, rise, fall;
  logic             pulse_bit, timeout, is_glitch, last_bit;
  logic             perr_n, ferr_n, ovr_n, load;

  swim_sync u_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .din    (swim_in),
    .level  (level),
    .rise   (rise),
    .fall   (fall)
  );

  assign cnt_inc   = (&cnt) ? cnt : cnt + 1'b1;
  assign timeout   = (cnt_inc == CNT_W'(TIMEOUT));
  assign pulse_bit = (cnt < CNT_W'(BIT_THRESH));
  assign is_glitch = (cnt < CNT_W'(GLITCH_MIN));
  assign last_bit  = (bit_cnt == 4'(SWIM_FRAME_BITS - 1));
  // Frame as it stands once the bit now ending is shifted in: [9]=header, [0]=parity.
  assign frame     = {shreg[8:0], pulse_bit};

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    perr_n    = 1'b0;
    ferr_n    = 1'b0;
    ovr_n     = 1'b0;
    load      = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_n     = '0;
        bit_cnt_n = '0;
        if (fall) begin
          state_n = ST_LOW;
          cnt_n   = CNT_W'(1);
        end
      end
      ST_LOW: begin
        cnt_n = cnt_inc;
        if (rise) begin
          cnt_n = '0;
          if (is_glitch) begin
            state_n = (bit_cnt == '0) ? ST_IDLE : ST_HIGH;
          end else if (bit_cnt == '0 && !pulse_bit) begin
            ferr_n  = 1'b1;
            state_n = ST_DISCARD;
          end else if (last_bit) begin
            // Frame completes on the same edge the parity bit is taken.
            bit_cnt_n = '0;
            state_n   = ST_IDLE;
            if ((^frame[8:1]) != frame[0]) perr_n = 1'b1;
            else if (out_valid && !out_ready) ovr_n = 1'b1;
            else load = 1'b1;
          end else begin
            shreg_n   = frame;
            bit_cnt_n = bit_cnt + 1'b1;
            state_n   = ST_HIGH;
          end
        end else if (timeout) begin
          ferr_n    = 1'b1;
          bit_cnt_n = '0;
          state_n   = ST_STUCK;
        end
      end
      ST_HIGH: begin
        cnt_n = cnt_inc;
        if (fall) begin
          state_n = ST_LOW;
          cnt_n   = CNT_W'(1);
        end else if (timeout) begin
          ferr_n    = 1'b1;
          bit_cnt_n = '0;
          state_n   = ST_IDLE;
        end
      end
      ST_STUCK: begin
        cnt_n     = '0;
        bit_cnt_n = '0;
        if (rise) state_n = ST_IDLE;
      end
      ST_DISCARD: begin
        // Bad header: ignore the rest of the frame until the line idles high.
        bit_cnt_n = '0;
        cnt_n     = (rise || fall) ? '0 : cnt_inc;
        if (!rise && !fall && timeout && level) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
    if (!en) begin
      state_n   = ST_IDLE;
      cnt_n     = '0;
      bit_cnt_n = '0;
      perr_n    = 1'b0;
      ferr_n    = 1'b0;
      ovr_n     = 1'b0;
      load      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bit_cnt    <= bit_cnt_n;
      shreg      <= shreg_n;
      parity_err <= perr_n;
      frame_err  <= ferr_n;
      overrun    <= ovr_n;
      if (load) begin
        out_data  <= frame[8:1];
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_swim_rx.sv
// Scoreboard bench for swim_rx: stimulus pushes expected events, a monitor
// pops and compares them as the DUT emits bytes and error pulses.
module tb_swim_rx;
  import swim_rx_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       swim_in;
  logic       en;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;

  typedef enum int {EV_BYTE, EV_PERR, EV_FERR, EV_OVR} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [7:0] data;
  } ev_t;

  ev_t sb[$];
  int  checks = 0;
  int  errors = 0;

  swim_rx dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .swim_in   (swim_in),
    .en        (en),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic expect_event(input ev_kind_t kind, input logic [7:0] data);
    ev_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event got kind=%0d data=%0h expected none", kind, data);
    end else begin
      e = sb.pop_front();
      check("event_kind", kind, e.kind);
      if (e.kind == EV_BYTE) check("event_byte", data, e.data);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (parity_err) expect_event(EV_PERR, 8'h00);
      if (frame_err)  expect_event(EV_FERR, 8'h00);
      if (overrun)    expect_event(EV_OVR,  8'h00);
      if (out_valid && out_ready) expect_event(EV_BYTE, out_data);
    end
  end

  task automatic push(input ev_kind_t kind, input logic [7:0] data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    sb.push_back(e);
  endtask

  // Sends the first nbits of {header=1, data MSB first, parity}; returns right
  // after the last rising edge. glitch_at inserts a 2-cycle low in that bit's high phase.
  task automatic send_frame(input logic [7:0] data, input logic par, input int nbits,
                            input int glitch_at);
    logic [9:0] bits;
    int         low;
    bits = {1'b1, data, par};
    for (int i = 0; i < nbits; i++) begin
      low = bits[9-i] ? SWIM_SHORT_LOW : SWIM_LONG_LOW;
      swim_in = 1'b0;
      repeat (low) @(negedge clk);
      swim_in = 1'b1;
      if (i != nbits - 1) begin
        if (i == glitch_at) begin
          repeat (50) @(negedge clk);
          swim_in = 1'b0;
          repeat (2) @(negedge clk);
          swim_in = 1'b1;
          repeat (SWIM_BIT_PERIOD - low - 52) @(negedge clk);
        end else begin
          repeat (SWIM_BIT_PERIOD - low) @(negedge clk);
        end
      end
    end
  endtask

  task automatic wait_drain(input string name, input int max);
    int n = 0;
    while (sb.size() != 0 && n < max) begin
      @(negedge clk);
      n++;
    end
    check(name, sb.size(), 0);
  endtask

  task automatic wait_valid(input string name, input int max);
    int n = 0;
    while (!out_valid && n < max) begin
      @(negedge clk);
      n++;
    end
    check(name, out_valid, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_n   = 1'b0;
    swim_in   = 1'b1;
    en        = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out_data", out_data, 8'h00);
    check("reset_busy", busy, 1'b0);
    check("reset_pulses", {parity_err, frame_err, overrun}, 3'b000);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);

    // 1: 0x5A, latency 3 clk from last rise
    push(EV_BYTE, 8'h5A);
    send_frame(8'h5A, 1'b0, 10, -1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 10);
    check("t1_latency", n, 3);
    check("t1_data", out_data, 8'h5A);
    wait_drain("t1_drain", 10);
    repeat (20) @(negedge clk);

    // 2: 0xFF with wrong parity
    push(EV_PERR, 8'h00);
    send_frame(8'hFF, 1'b1, 10, -1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!parity_err && n < 10);
    check("t2_perr_seen", parity_err, 1'b1);
    check("t2_out_valid", out_valid, 1'b0);
    @(negedge clk);
    check("t2_busy_low", busy, 1'b0);
    check("t2_perr_single", parity_err, 1'b0);
    wait_drain("t2_drain", 5);
    repeat (20) @(negedge clk);

    // 3: glitch in high phase of data bit 3 of 0xA5
    push(EV_BYTE, 8'hA5);
    send_frame(8'hA5, 1'b0, 10, 3);
    wait_drain("t3_drain", 20);
    repeat (20) @(negedge clk);

    // 4: overrun while 0x11 held, then release
    out_ready = 1'b0;
    send_frame(8'h11, 1'b0, 10, -1);
    wait_valid("t4_valid_11", 20);
    check("t4_data_11", out_data, 8'h11);
    repeat (20) @(negedge clk);
    push(EV_OVR, 8'h00);
    send_frame(8'h22, 1'b0, 10, -1);
    wait_drain("t4_ovr_drain", 20);
    check("t4_data_held", out_data, 8'h11);
    check("t4_valid_held", out_valid, 1'b1);
    push(EV_BYTE, 8'h11);
    out_ready = 1'b1;
    wait_drain("t4_xfer_drain", 5);
    @(negedge clk);
    check("t4_valid_clear", out_valid, 1'b0);
    repeat (20) @(negedge clk);

    // 5: 5 bits then idle -> frame_err at TIMEOUT; then 0x3C held for test 6
    push(EV_FERR, 8'h00);
    send_frame(8'h3C, 1'b0, 5, -1);
    repeat (2000) @(negedge clk);
    check("t5_no_early_ferr", sb.size(), 1);
    wait_drain("t5_ferr_drain", 200);
    repeat (20) @(negedge clk);
    out_ready = 1'b0;
    send_frame(8'h3C, 1'b0, 10, -1);
    wait_valid("t5_valid_3c", 20);
    check("t5_data_3c", out_data, 8'h3C);
    repeat (20) @(negedge clk);

    // 6a: async reset mid-frame
    send_frame(8'hC3, 1'b0, 6, -1);
    swim_in = 1'b0;
    repeat (30) @(negedge clk);
    check("t6_busy_before", busy, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("t6_rst_valid", out_valid, 1'b0);
    check("t6_rst_data", out_data, 8'h00);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_pulses", {parity_err, frame_err, overrun}, 3'b000);
    @(negedge clk);
    swim_in = 1'b1;
    reset_n = 1'b1;
    out_ready = 1'b1;
    repeat (10) @(negedge clk);
    push(EV_BYTE, 8'hC3);
    send_frame(8'hC3, 1'b0, 10, -1);
    wait_drain("t6_rst_c3", 20);
    repeat (20) @(negedge clk);

    // 6b: en=0 mid-frame, no error pulse, next frame clean
    send_frame(8'hC3, 1'b0, 6, -1);
    repeat (20) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("t6_en_busy", busy, 1'b0);
    repeat (10) @(negedge clk);
    en = 1'b1;
    repeat (10) @(negedge clk);
    push(EV_BYTE, 8'hC3);
    send_frame(8'hC3, 1'b0, 10, -1);
    wait_drain("t6_en_c3", 20);
    repeat (50) @(negedge clk);

    check("final_scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
